// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, instruction fields, state encoding and helpers for alu_seq_ctrl
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int NREGS = 8;

  // ALU opcode encoding (011 and 101 are illegal)
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_LDI = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  // Instruction field bit positions
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 13;
  localparam int RD_HI   = 12;
  localparam int RD_LO   = 10;
  localparam int RS_HI   = 9;
  localparam int RS_LO   = 7;
  localparam int RT_HI   = 6;
  localparam int RT_LO   = 4;
  localparam int IMM_BIT = 3;

  // Controller state encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

  function automatic logic is_legal(input logic [2:0] op);
    return is_alu_op(op) || (op == OP_LDI);
  endfunction

  function automatic logic [WIDTH-1:0] sext10(input logic [9:0] v);
    return {{(WIDTH-10){v[9]}}, v};
  endfunction

  function automatic logic [WIDTH-1:0] sext3(input logic [2:0] v);
    return {{(WIDTH-3){v[2]}}, v};
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - 8x16 register file, one sync write, two operand reads, one debug read, R0 hardwired to zero
module alu_seq_regfile
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [2:0]       waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [2:0]       raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [2:0]       raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs [NREGS];

  // Clear on reset; writes to R0 are dropped so it stays zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != 3'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = (raddr_a  == 3'd0) ? '0 : regs[raddr_a];
  assign rdata_b  = (raddr_b  == 3'd0) ? '0 : regs[raddr_b];
  assign dbg_data = (dbg_addr == 3'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - IDLE/EXEC/WB sequencer feeding an external ALU; ALU_SEQ_IMM_EN enables 3-bit immediate operand B
module alu_seq_ctrl
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_s,
  output logic             done,
  output logic [WIDTH-1:0] res_data,
  output logic [2:0]       res_rd,
  output logic             err,
  input  logic [2:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [1:0]       state;
  logic [15:0]      ir;
  logic [WIDTH-1:0] result;
  logic             illegal;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic [WIDTH-1:0] opb;
  logic [2:0]       op;
  logic [2:0]       rd;
  logic             in_exec;
  logic             in_wb;

  assign op = ir[OP_HI:OP_LO];
  assign rd = ir[RD_HI:RD_LO];

  // Reset masks every output so an aborted instruction leaves no trace
  assign in_exec     = (state == EXEC) && !rst;
  assign in_wb       = (state == WB) && !rst;
  assign instr_ready = (state == IDLE) && !rst;

`ifdef ALU_SEQ_IMM_EN
  assign opb = (is_alu_op(op) && ir[IMM_BIT]) ? sext3(ir[2:0]) : rt_val;
`else
  assign opb = rt_val;
`endif

  assign alu_x  = in_exec ? rs_val : '0;
  assign alu_y  = in_exec ? opb : '0;
  assign alu_op = in_exec ? op : 3'b000;

  assign done     = in_wb && !illegal;
  assign err      = in_wb && illegal;
  assign res_data = done ? result : '0;
  assign res_rd   = done ? rd : 3'd0;

  alu_seq_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (done),
    .waddr    (rd),
    .wdata    (result),
    .raddr_a  (ir[RS_HI:RS_LO]),
    .rdata_a  (rs_val),
    .raddr_b  (ir[RT_HI:RT_LO]),
    .rdata_b  (rt_val),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // Three-state sequencer: accept, capture the ALU (or immediate) result, write back
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ir      <= '0;
      result  <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= EXEC;
          end
        end
        EXEC: begin
          result  <= (op == OP_LDI) ? sext10(ir[9:0]) : alu_s;
          illegal <= !is_legal(op);
          state   <= WB;
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - randomized self-checking bench for alu_seq_ctrl against a register-array reference model
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_x, alu_y, alu_s, res_data, dbg_data;
  logic [2:0]  alu_op, res_rd, dbg_addr;
  logic        done, err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] model [8];

  alu_seq_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_s(alu_s),
    .done(done), .res_data(res_data), .res_rd(res_rd), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Ideal ALU behaviour
  function automatic logic [15:0] ideal_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_s = ideal_alu(alu_op, alu_x, alu_y);

  function automatic logic [15:0] mk(input int op, input int rd, input int rs, input int rt, input int ext);
    logic [15:0] v;
    v = {op[2:0], rd[2:0], rs[2:0], rt[2:0], ext[3:0]};
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One instruction through the full accept/EXEC/WB sequence; entered and left at a negedge
  task automatic run(input logic [15:0] ins);
    logic [2:0]  op, rd, rs, rt;
    logic [15:0] a, b, expv, imm;
    logic        is_alu, legal;
    op = ins[15:13]; rd = ins[12:10]; rs = ins[9:7]; rt = ins[6:4];
    a = model[rs];
    b = model[rt];
    is_alu = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) || (op == 3'b110) || (op == 3'b111);
    legal  = is_alu || (op == 3'b100);
`ifdef ALU_SEQ_IMM_EN
    if (is_alu && ins[3]) b = 16'($signed(ins[2:0]));
`endif
    imm  = 16'($signed(ins[9:0]));
    expv = (op == 3'b100) ? imm : ideal_alu(op, a, b);

    check("idle_ready", instr_ready, 1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check("exec_ready", instr_ready, 0);
    check("exec_done", done, 0);
    check("exec_err", err, 0);
    check("exec_op", alu_op, op);
    if (is_alu) begin
      check("exec_x", alu_x, a);
      check("exec_y", alu_y, b);
    end
    @(negedge clk);
    check("wb_ready", instr_ready, 0);
    check("wb_done", done, legal);
    check("wb_err", err, !legal);
    check("wb_data", res_data, legal ? expv : 16'h0);
    check("wb_rd", res_rd, legal ? rd : 3'd0);
    check("wb_alu_x_zero", alu_x, 0);
    if (legal && rd != 3'd0) model[rd] = expv;
    dbg_addr = rd;
    @(negedge clk);
    check("dbg_after_wb", dbg_data, model[rd]);
    check("post_done", done, 0);
  endtask

  initial begin
    logic [15:0] held [3];
    int acc [3];
    int idx;
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    rst = 1'b1; instr_valid = 1'b0; instr = 16'h0; dbg_addr = 3'd0;

    // Reset held for three cycles
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_ready", instr_ready, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_alu_x", alu_x, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", instr_ready, 1);
    for (int r = 0; r < 8; r++) begin
      dbg_addr = 3'(r);
      #1 check("rst_dbg", dbg_data, 0);
    end

    // Directed sequence
    run(mk(4, 1, 0, 0, 5));          // LDI R1 = 5
    run(mk(4, 2, 0, 0, 3));          // LDI R2 = 3
    run(mk(2, 3, 1, 2, 0));          // ADD R3 = R1 + R2
    check("add_model", model[3], 16'h0008);
    run(mk(6, 4, 2, 1, 0));          // SUB R4 = R2 - R1
    check("sub_model", model[4], 16'hFFFE);
    run(mk(7, 5, 1, 2, 0));          // SLT R5 = R1 < R2
    check("slt_model", model[5], 16'h0000);
    run({3'b100, 3'd6, 10'h3FF});    // LDI R6 = sext(0x3FF)
    check("ldi_model", model[6], 16'hFFFF);
    run(mk(3, 2, 1, 1, 0));          // illegal 011, rd = 2
    check("illegal_r2", model[2], 16'h0003);
    run(mk(5, 1, 2, 2, 0));          // illegal 101
    run(mk(2, 0, 1, 2, 0));          // write to R0 is discarded

    // instr_valid held across three instructions
    held[0] = mk(2, 7, 1, 1, 0);
    held[1] = mk(1, 6, 7, 4, 0);
    held[2] = mk(4, 5, 0, 0, 9);
    instr = held[0];
    instr_valid = 1'b1;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      check("held_ready", instr_ready, (c % 3 == 0) && (c < 9) ? 1 : ((c == 9) ? 1 : 0));
      if (instr_ready && instr_valid && idx < 3) begin
        acc[idx] = c;
        idx++;
        @(posedge clk);
        #1;
        if (idx < 3) instr = held[idx];
        else instr_valid = 1'b0;
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
    check("held_count", idx, 3);
    if (idx == 3) begin
      check("held_gap1", acc[1] - acc[0], 3);
      check("held_gap2", acc[2] - acc[1], 3);
    end
    model[7] = model[1] + model[1];
    model[6] = model[7] | model[4];
    model[5] = 16'h0009;
    for (int r = 5; r < 8; r++) begin
      dbg_addr = 3'(r);
      #1 check("held_dbg", dbg_data, model[r]);
    end
    @(negedge clk);

    // Randomized instructions
    for (int n = 0; n < 60; n++) begin
      run(16'($urandom));
    end

    // Reset during EXEC aborts the instruction
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    @(negedge clk);
    run(mk(4, 1, 0, 0, 5));
    run(mk(4, 2, 0, 0, 3));
    instr = mk(2, 7, 1, 2, 0);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check("abort_in_exec", alu_op, 3'b010);
    rst = 1'b1;
    #1 check("abort_alu_zero", alu_x, 0);
    @(negedge clk);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    check("abort_ready_in_rst", instr_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", instr_ready, 1);
    check("abort_no_done", done, 0);
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    dbg_addr = 3'd7;
    #1 check("abort_r7", dbg_data, 0);
    @(negedge clk);
    run(mk(2, 3, 1, 2, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Sequencing front end that drives the 16-bit combinational ALU (aluIn).
- Accepts 16-bit instructions over a valid/ready handshake.
- Reads operands from an internal 8x16 register file and drives x/y/opcode to the ALU.
- Captures the ALU result and writes it back to the register file.
- Produces the operand/opcode stream that the ALU consumes, and retires its results.

Parameters:
- NREGS, 8, register-file depth; fixed at 8 (3-bit register fields).
- WIDTH, 16, datapath width; must equal the ALU width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction present on instr.
- instr_ready  out  1  controller can accept an instruction.
- instr  in  16  [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt, [3:0] ext.
- alu_x  out  16  operand A to ALU.
- alu_y  out  16  operand B to ALU.
- alu_op  out  3  ALU opcode.
- alu_s  in  16  ALU result (combinational from alu_x/alu_y/alu_op).
- done  out  1  one-cycle pulse at writeback.
- res_data  out  16  value written at writeback.
- res_rd  out  3  destination written at writeback.
- err  out  1  one-cycle pulse on illegal opcode.
- dbg_addr  in  3  register-file debug read address.
- dbg_data  out  16  combinational R[dbg_addr].

Behaviour:
- Opcodes, matching the ALU encoding:
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
  - 100 LDI: R[rd] <= sign-extend(instr[9:0]); the ALU is not used.
  - 011 and 101 are illegal.
- Register file:
  - R0 always reads 0; writes to R0 are discarded, but done still pulses.
  - All registers are cleared by reset.
- FSM has three states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready = 1 (forced 0 while rst = 1).
  - On instr_valid && instr_ready, latch instr into ir and go to EXEC.
- EXEC (1 cycle):
  - Drive alu_x = R[ir.rs], alu_y = R[ir.rt], alu_op = ir.op.
  - Register alu_s into result at the clock edge.
  - For LDI, result = sext(ir[9:0]).
  - For an illegal op: pulse err in the next cycle (WB), with no write and no done.
  - Go to WB.
- WB (1 cycle):
  - R[ir.rd] <= result; done = 1; res_data = result; res_rd = ir.rd.
  - Return to IDLE.
- Outside EXEC, alu_x, alu_y and alu_op are 0.
- Timing:
  - Latency is 2 cycles from the accept edge to the done pulse.
  - Throughput is 1 instruction per 3 cycles.
  - instr_ready is low in EXEC and WB, so a held instr_valid waits.
- Hazards: none. Writeback completes before the next instruction reads the file.
- ALU result: the block passes alu_s through unmodified and never interprets SLT or carry.
- Reset:
  - Values: state IDLE, all registers 0, done = err = 0, res_data = 0, res_rd = 0, alu_* = 0.
  - Reset in EXEC or WB aborts the instruction with no register write and no pulses.
- dbg_data is combinational and reflects a WB write on the following cycle.

Optional Feature:
- Macro: ALU_SEQ_IMM_EN.
- Defined:
  - For ALU ops with ir[3] = 1, alu_y = sign-extend(ir[2:0]) (range -4..3) instead of R[rt].
  - For ALU ops with ir[3] = 0, behaviour is unchanged.
- Undefined: ir[3:0] is ignored for ALU ops.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_LDI=3'b100, OP_SUB=3'b110, OP_SLT=3'b111.
  - Instruction field bit positions.
  - State encoding IDLE=2'd0, EXEC=2'd1, WB=2'd2.
  - WIDTH.
- One sub-module: alu_seq_regfile.
  - 8x16, one synchronous write port.
  - Two combinational read ports plus a debug read port.
  - Implements the R0-is-zero rule.

Test Plan:
- Reset: hold rst 3 cycles → instr_ready=0 during rst, then 1; done/err=0; dbg_data=0 for all addresses.
- LDI R1=5, LDI R2=3, then ADD R3=R1+R2 (with an ideal ALU model) → done with res_rd=3, res_data=0x0008; alu_x=5, alu_y=3, alu_op=010 in EXEC; dbg R3=0x0008.
- SUB R4=R2-R1 → res_data=0xFFFE; SLT R5=R1,R2 with an ideal model → res_data=0x0000; LDI R6=0x3FF → 0xFFFF.
- Opcode 011 with rd=2 → err pulses exactly in the WB cycle, no done, and R2 is unchanged (still 3).
- instr_valid held high across 3 instructions → instr_ready low for 2 cycles after each accept; accepts are exactly 3 cycles apart.
- rst asserted during EXEC of ADD R7 → no done, R7 stays 0, FSM returns to IDLE, instr_ready=1 after rst drops.
